// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : Iterative RV32M multiply/divide unit (shift-add / restoring divide)
//            with its own control FSM; one operand bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      fun3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_prep  = 3'd1;
    localparam logic [2:0] c_st_calc  = 3'd2;
    localparam logic [2:0] c_st_fixup = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    localparam logic [CW-1:0]   c_last = CW'(XLEN - 1);
    localparam logic [CW-1:0]   c_one  = CW'(1);
    localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_ones = '1;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [2:0]        r_fun3;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_mag;
    logic              r_neg_a;
    logic              r_neg_b;
    logic [2*XLEN:0]   r_acc;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_is_div;
    logic              w_sgn_a;
    logic              w_sgn_b;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_val;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN:0]   w_mul_next;
    logic [XLEN+1:0]   w_diff;
    logic              w_borrow;
    logic [2*XLEN:0]   w_div_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix;

    assign w_accept = ((r_state == c_st_idle) || (r_state == c_st_done)) && start && !abort;
    assign w_is_div = r_fun3[2];

    // MULHSU treats only rs1 as signed; MUL/MULHU/DIVU/REMU are fully unsigned
    assign w_sgn_a = (r_fun3 == 3'b001) || (r_fun3 == 3'b010) ||
                     (r_fun3 == 3'b100) || (r_fun3 == 3'b110);
    assign w_sgn_b = (r_fun3 == 3'b001) || (r_fun3 == 3'b100) || (r_fun3 == 3'b110);
    assign w_neg_a = w_sgn_a && r_a[XLEN-1];
    assign w_neg_b = w_sgn_b && r_b[XLEN-1];
    assign w_mag_a = w_neg_a ? -r_a : r_a;
    assign w_mag_b = w_neg_b ? -r_b : r_b;

    assign w_div0     = w_is_div && (r_b == '0);
    assign w_ovf      = w_is_div && !r_fun3[0] && (r_a == c_min) && (r_b == c_ones);
    assign w_special  = w_div0 || w_ovf;
    assign w_spec_val = w_div0 ? (r_fun3[1] ? r_a : c_ones)
                               : (r_fun3[1] ? '0  : c_min);

    // Multiply: high half accumulates, low half holds the shrinking multiplier
    assign w_sum      = r_acc[2*XLEN:XLEN] + {1'b0, r_mag};
    assign w_mul_next = {1'b0, (r_acc[0] ? w_sum : r_acc[2*XLEN:XLEN]), r_acc[XLEN-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in
    assign w_diff     = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, r_mag};
    assign w_borrow   = w_diff[XLEN+1];
    assign w_div_next = {(w_borrow ? r_acc[2*XLEN-1:XLEN-1] : w_diff[XLEN:0]),
                         r_acc[XLEN-2:0], ~w_borrow};

    assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc[2*XLEN-1:0] : r_acc[2*XLEN-1:0];
    assign w_quot = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix = w_quot;
        case (r_fun3)
            3'b000:                 w_fix = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix = w_prod[2*XLEN-1:XLEN];
            3'b110, 3'b111:         w_fix = w_rem;
            default:                w_fix = w_quot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (start && !abort) w_next_state = c_st_prep;
            c_st_prep:  begin
                if (abort)          w_next_state = c_st_idle;
                else if (w_special) w_next_state = c_st_done;
                else                w_next_state = c_st_calc;
            end
            c_st_calc:  begin
                if (abort)                 w_next_state = c_st_idle;
                else if (r_cnt == c_last)  w_next_state = c_st_fixup;
            end
            c_st_fixup: w_next_state = abort ? c_st_idle : c_st_done;
            c_st_done:  w_next_state = (start && !abort) ? c_st_prep : c_st_idle;
            default:    w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        busy = (r_state == c_st_prep) || (r_state == c_st_calc) || (r_state == c_st_fixup);
        done = (r_state == c_st_done);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fun3   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_mag    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (w_accept) begin
                        r_fun3 <= fun3;
                        r_a    <= op_a;
                        r_b    <= op_b;
                    end
                end
                c_st_prep: begin
                    r_neg_a <= w_neg_a;
                    r_neg_b <= w_neg_b;
                    r_mag   <= w_is_div ? w_mag_b : w_mag_a;
                    r_acc   <= {{(XLEN+1){1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                    r_cnt   <= '0;
                    if (w_special && !abort) r_result <= w_spec_val;
                end
                c_st_calc: begin
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + c_one;
                end
                c_st_fixup: begin
                    if (!abort) r_result <= w_fix;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Brief    : Self-checking bench for muldiv_sequencer against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
    localparam int XLEN = 32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  fun3  = 3'b000;
    logic [31:0] op_a  = '0;
    logic [31:0] op_b  = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .fun3   (fun3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return 35;
    endfunction

    // Model: cycles of busy remaining, pending result, and what the outputs must be
    int          m_rem    = 0;
    logic        m_done   = 1'b0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend   = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem = 0; m_done = 1'b0; m_result = '0;
        end else if (abort) begin
            m_rem = 0; m_done = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            m_done = (m_rem == 0);
            if (m_rem == 0) m_result = m_pend;
        end else if (start) begin
            m_pend = ref_result(fun3, op_a, op_b);
            m_rem  = ref_latency(fun3, op_a, op_b) - 1;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
        end
        #1;
        check("cyc busy",   32'(busy), 32'(m_rem > 0));
        check("cyc done",   32'(done), 32'(m_done));
        check("cyc result", result,    m_result);
    end

    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        fun3 = f; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fun3  = 3'($urandom_range(7));
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        launch(f, a, b);
        wait_done(1, n);
        check({name, " latency"}, 32'(n), 32'(lat));
        check({name, " result"},  result, exp);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int dcount;

        check("model MUL",    ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("model MULHSU", ref_result(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("model REM",    ref_result(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("MUL",        3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        run_op("MULHU",      3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 35);
        run_op("MULH",       3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 35);
        run_op("MULHSU",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
        run_op("MULH min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
        run_op("DIV",        3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
        run_op("REM",        3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
        run_op("DIVU",       3'd5, 32'd100, 32'd7, 32'd14, 35);
        run_op("REMU",       3'd7, 32'd100, 32'd7, 32'd2, 35);
        run_op("DIVU by0",   3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("REM by0",    3'd6, 32'd5, 32'd0, 32'd5, 2);
        run_op("DIV ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("REM ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);

        // Back-to-back: start held during the DONE cycle
        launch(3'd5, 32'd100, 32'd7);
        wait_done(1, n);
        check("b2b first latency", 32'(n), 32'd35);
        fun3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b busy", 32'(busy), 32'd1);
        check("b2b done", 32'(done), 32'd0);
        wait_done(1, n);
        check("b2b second latency", 32'(n), 32'd35);
        check("b2b second result",  result, 32'hFFFF_FFEB);
        @(posedge clk); #1;

        // Start pulsed mid-CALC is ignored
        launch(3'd5, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        fun3 = 3'd0; op_a = 32'd3; op_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(11, n);
        check("guard latency", 32'(n), 32'd35);
        check("guard result",  result, 32'd14);
        @(posedge clk); #1;

        // Abort in cycle 20
        launch(3'd3, 32'd7, 32'hFFFF_FFFD);
        repeat (19) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
        end
        check("abort no done", 32'(dcount), 32'd0);
        check("abort result",  result, 32'd14);

        // Reset mid-CALC
        launch(3'd0, 32'd7, 32'hFFFF_FFFD);
        repeat (14) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("reset result", result, 32'd0);
        check("reset busy",   32'(busy), 32'd0);
        repeat (3) begin @(posedge clk); #1; end

        // Random traffic; the model process checks every cycle
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(3) == 0);
            abort = ($urandom_range(60) == 0);
            rst_n = ($urandom_range(800) != 0);
            fun3  = 3'($urandom_range(7));
            op_a  = pick();
            op_b  = pick();
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
